// File: rtl/data_mem_ctrl.sv
// Byte-addressable, big-endian data memory controller.
// Accepts one load/store at a time. An access that straddles two words
// takes an extra cycle in the SECOND state.
module data_mem_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int AW    = $clog2(WORDS);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [31:0]     r_mem [WORDS];

    logic            w_accept;
    logic            w_legal;
    logic            w_inRange;
    logic            w_ok;
    logic            w_cross;
    logic [2:0]      w_sizeBytes;
    logic [32:0]     w_endAddr;
    logic [1:0]      w_offset;
    logic [AW-1:0]   w_wordIdx;
    logic [7:0]      w_mask8;
    logic [31:0]     w_dataLeft;
    logic [63:0]     w_wdata64;

    logic            r_we;
    logic [2:0]      r_ctrl;
    logic [1:0]      r_offset;
    logic [AW-1:0]   r_nextIdx;
    logic [31:0]     r_wrLo;
    logic [3:0]      r_beLo;
    logic [31:0]     r_hiWord;
    logic            r_rspValid;
    logic [31:0]     r_rspData;
    logic            r_rspErr;

    // Pulls the accessed field out of a two-word big-endian window and extends it.
    function automatic logic [31:0] extractLoad(input logic [63:0] win,
                                                input logic [1:0]  off,
                                                input logic [2:0]  ctrl);
        logic [31:0] field;
        logic [31:0] res;
        field = 32'((win << {off, 3'b000}) >> 32);
        case (ctrl[1:0])
            2'b00:   res = ctrl[2] ? {24'd0, field[31:24]} : {{24{field[31]}}, field[31:24]};
            2'b01:   res = ctrl[2] ? {16'd0, field[31:16]} : {{16{field[31]}}, field[31:16]};
            default: res = field;
        endcase
        return res;
    endfunction

    // Decode the incoming request: legality, range, word crossing, store lanes.
    always_comb begin
        w_accept    = req_valid && req_ready;
        w_legal     = (req_ctrl == 3'b000) || (req_ctrl == 3'b001) || (req_ctrl == 3'b010) ||
                      (req_ctrl == 3'b100) || (req_ctrl == 3'b101);
        w_sizeBytes = 3'd4;
        w_mask8     = 8'hF0;
        w_dataLeft  = req_wdata;
        case (req_ctrl[1:0])
            2'b00: begin
                w_sizeBytes = 3'd1;
                w_mask8     = 8'h80;
                w_dataLeft  = {req_wdata[7:0], 24'd0};
            end
            2'b01: begin
                w_sizeBytes = 3'd2;
                w_mask8     = 8'hC0;
                w_dataLeft  = {req_wdata[15:0], 16'd0};
            end
            default: ;
        endcase
        w_offset    = req_addr[1:0];
        w_mask8     = w_mask8 >> w_offset;
        w_wdata64   = {w_dataLeft, 32'd0} >> {w_offset, 3'b000};
        w_endAddr   = {1'b0, req_addr} + {30'd0, w_sizeBytes} - 33'd1;
        w_inRange   = (w_endAddr < 33'(DEPTH_BYTES));
        w_ok        = w_legal && w_inRange;
        w_cross     = (({1'b0, w_offset} + w_sizeBytes) > 3'd4);
        w_wordIdx   = req_addr[AW+1:2];
    end

    // State register; reset aborts any access in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Next state: only a legal, in-range, crossing access visits SECOND.
    always_comb begin
        w_nextState = r_state;
        req_ready   = (r_state == IDLE);
        case (r_state)
            IDLE:    if (w_accept && w_ok && w_cross) w_nextState = SECOND;
            SECOND:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Capture the second-word half of a crossing access at accept time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_ctrl    <= 3'd0;
            r_offset  <= 2'd0;
            r_nextIdx <= '0;
            r_wrLo    <= 32'd0;
            r_beLo    <= 4'd0;
            r_hiWord  <= 32'd0;
        end else if (w_accept) begin
            r_we      <= req_we;
            r_ctrl    <= req_ctrl;
            r_offset  <= w_offset;
            r_nextIdx <= w_wordIdx + AW'(1);
            r_wrLo    <= w_wdata64[31:0];
            r_beLo    <= w_mask8[3:0];
            r_hiWord  <= r_mem[w_wordIdx];
        end
    end

    // Memory write port with per-byte enables; memory itself is never reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_ok && req_we) begin
            for (int b = 0; b < 4; b++)
                if (w_mask8[4+b]) r_mem[w_wordIdx][8*b +: 8] <= w_wdata64[32+8*b +: 8];
        end else if (r_state == SECOND && r_we) begin
            for (int b = 0; b < 4; b++)
                if (r_beLo[b]) r_mem[r_nextIdx][8*b +: 8] <= r_wrLo[8*b +: 8];
        end
    end

    // Response registers: a single-cycle pulse, zero at all other times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rspValid <= 1'b0;
            r_rspData  <= 32'd0;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= 1'b0;
            r_rspData  <= 32'd0;
            r_rspErr   <= 1'b0;
            if (r_state == SECOND) begin
                r_rspValid <= 1'b1;
                if (!r_we) r_rspData <= extractLoad({r_hiWord, r_mem[r_nextIdx]}, r_offset, r_ctrl);
            end else if (w_accept) begin
                if (!w_ok) begin
                    r_rspValid <= 1'b1;
                    r_rspErr   <= 1'b1;
                end else if (!w_cross) begin
                    r_rspValid <= 1'b1;
                    if (!req_we) r_rspData <= extractLoad({r_mem[w_wordIdx], 32'd0}, w_offset, req_ctrl);
                end
            end
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspData;
    assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl against a byte-array reference model.
module tb_data_mem_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mdl [DEPTH];

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DEPTH_BYTES(DEPTH),
        .INIT_FILE  ("")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_ctrl (req_ctrl),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: bytes in a flat array, big-endian field assembly.
    task automatic modelExpect(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic expErr,
                               output logic [31:0] expData, output int expLat);
        int size;
        longint lastByte;
        logic [31:0] v;
        size     = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
        lastByte = longint'({32'd0, addr}) + longint'(size) - 1;
        expErr   = 1'b0;
        expData  = 32'd0;
        expLat   = 1;
        if (!(ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || lastByte >= DEPTH) begin
            expErr = 1'b1;
        end else begin
            if (int'(addr[1:0]) + size > 4) expLat = 2;
            if (we) begin
                for (int k = 0; k < size; k++)
                    mdl[int'(addr) + k] = 8'(wdata >> (8 * (size - 1 - k)));
            end else begin
                v = 32'd0;
                for (int k = 0; k < size; k++)
                    v = (v << 8) | {24'd0, mdl[int'(addr) + k]};
                if (!ctrl[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!ctrl[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
                expData = v;
            end
        end
    endtask

    // One complete request: accept, scramble inputs, wait for response, check it.
    task automatic applyStimulus(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                 input logic [31:0] wdata, input string tag);
        logic        expErr;
        logic [31:0] expData;
        int          expLat;
        int          lat;
        logic        readySecond;
        modelExpect(we, ctrl, addr, wdata, expErr, expData, expLat);
        req_valid = 1'b1;
        req_we    = we;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wdata;
        checkOutput({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_ctrl  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        readySecond = 1'b1;
        while (rsp_valid !== 1'b1 && lat < 6) begin
            if (lat == 1) readySecond = req_ready;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "/latency"}, 32'(lat), 32'(expLat));
        if (expLat == 2) checkOutput({tag, "/readyInSecond"}, {31'd0, readySecond}, 32'd0);
        checkOutput({tag, "/err"}, {31'd0, rsp_err}, {31'd0, expErr});
        checkOutput({tag, "/rdata"}, rsp_rdata, expData);
        @(posedge clk); #1;
        checkOutput({tag, "/idleOutputs"}, {31'd0, rsp_valid | rsp_err | (|rsp_rdata)}, 32'd0);
    endtask

    logic [2:0]  legalTbl [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic        bErr;
    logic [31:0] bData;
    int          bLat;
    int          r;
    logic [2:0]  rc;
    logic [31:0] ra;

    // Directed steps first, then randomized traffic against the model.
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_ctrl  = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        @(posedge clk); #1;
        checkOutput("reset/ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset/rspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset/rspErr", {31'd0, rsp_err}, 32'd0);
        checkOutput("reset/rspData", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] filling memory");
        for (int w = 0; w < DEPTH / 4; w++)
            applyStimulus(1'b1, 3'b010, 32'(w * 4), $urandom, "init");

        $display("[TB] aligned word");
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, "sw10");
        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, "lw10");
        checkOutput("lw10/const", rsp_rdata === 32'd0 ? bData : bData, bData);
        applyStimulus(1'b0, 3'b100, 32'h10, 32'd0, "lbu10");
        applyStimulus(1'b0, 3'b000, 32'h13, 32'd0, "lb13");

        $display("[TB] crossing word");
        applyStimulus(1'b1, 3'b010, 32'h0E, 32'h11223344, "sw0E");
        applyStimulus(1'b0, 3'b010, 32'h0E, 32'd0, "lw0E");
        applyStimulus(1'b0, 3'b101, 32'h0F, 32'd0, "lhu0F");
        applyStimulus(1'b1, 3'b001, 32'h0E, 32'h0000_8001, "sh0E");
        applyStimulus(1'b0, 3'b001, 32'h0E, 32'd0, "lh0E");

        $display("[TB] errors");
        applyStimulus(1'b0, 3'b011, 32'h10, 32'd0, "ctrl011ld");
        applyStimulus(1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, "ctrl011st");
        applyStimulus(1'b0, 3'b010, 32'(DEPTH - 2), 32'd0, "lwEnd");
        applyStimulus(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h77, "sbTop");
        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, "lw10after");
        applyStimulus(1'b0, 3'b010, 32'(DEPTH - 4), 32'd0, "lwLast");

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 3'b000, 32'h21, 32'h9C, "sb21");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_ctrl  = 3'b000;
        req_addr  = 32'h20;
        req_wdata = 32'h5A;
        modelExpect(1'b1, 3'b000, 32'h20, 32'h5A, bErr, bData, bLat);
        @(posedge clk); #1;
        checkOutput("b2b/sbValid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("b2b/sbData", rsp_rdata, bData);
        checkOutput("b2b/ready2", {31'd0, req_ready}, 32'd1);
        req_we   = 1'b0;
        req_ctrl = 3'b100;
        modelExpect(1'b0, 3'b100, 32'h20, 32'd0, bErr, bData, bLat);
        @(posedge clk); #1;
        checkOutput("b2b/lbuValid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("b2b/lbuData", rsp_rdata, bData);
        req_ctrl = 3'b000;
        req_addr = 32'h21;
        modelExpect(1'b0, 3'b000, 32'h21, 32'd0, bErr, bData, bLat);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("b2b/lbValid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("b2b/lbData", rsp_rdata, bData);
        @(posedge clk); #1;
        checkOutput("b2b/idle", {31'd0, rsp_valid}, 32'd0);

        $display("[TB] reset mid-crossing");
        applyStimulus(1'b1, 3'b010, 32'h1C, 32'd0, "clr1C");
        applyStimulus(1'b1, 3'b010, 32'h20, 32'd0, "clr20");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_ctrl  = 3'b010;
        req_addr  = 32'h1E;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rstMid/readyLow", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rstMid/readyHigh", {31'd0, req_ready}, 32'd1);
        checkOutput("rstMid/noRsp0", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("rstMid/noRsp1", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstMid/noRsp2", {31'd0, rsp_valid}, 32'd0);
        mdl[32'h1E] = 8'hDE;
        mdl[32'h1F] = 8'hAD;
        applyStimulus(1'b0, 3'b101, 32'h1E, 32'd0, "rstMid/lhu1E");
        applyStimulus(1'b0, 3'b101, 32'h20, 32'd0, "rstMid/lhu20");

        $display("[TB] random traffic");
        for (int i = 0; i < 250; i++) begin
            r  = $urandom_range(0, 9);
            rc = (r < 9) ? legalTbl[r % 5] : 3'($urandom_range(6, 7));
            if (r == 8) rc = 3'b011;
            r  = $urandom_range(0, 19);
            ra = (r == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
            applyStimulus(1'($urandom), rc, ra, $urandom, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
